// File: rtl/psum_accum_ctrl_if.sv
// ---------------------------------------------------------------------------
// psum_accum_ctrl_if
// Bundles every non-clock/reset signal of the psum accumulation controller:
//   control   : start, num_psums, num_accum, busy, done
//   products  : prod_valid, prod_ready, prod_data (valid/ready stream in)
//   spad      : spad_w_en, spad_w_addr, spad_din, spad_r_addr, spad_rd_data
//   psum out  : psum_out_valid, psum_out_ready, psum_out_data (stream out)
// Modports:
//   slave  - the controller's view
//   master - the view of whatever drives the controller (PE glue / bench)
// ---------------------------------------------------------------------------
interface psum_accum_ctrl_if #(
    parameter int MEM_DEPTH  = 24,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int CNT_WIDTH  = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] num_psums;
    logic [CNT_WIDTH-1:0]  num_accum;
    logic                  busy;
    logic                  done;

    logic                  prod_valid;
    logic                  prod_ready;
    logic [DATA_WIDTH-1:0] prod_data;

    logic                  spad_w_en;
    logic [ADDR_WIDTH-1:0] spad_w_addr;
    logic [DATA_WIDTH-1:0] spad_din;
    logic [ADDR_WIDTH-1:0] spad_r_addr;
    logic [DATA_WIDTH-1:0] spad_rd_data;

    logic                  psum_out_valid;
    logic                  psum_out_ready;
    logic [DATA_WIDTH-1:0] psum_out_data;

    modport slave (
        input  start, num_psums, num_accum, prod_valid, prod_data,
               spad_rd_data, psum_out_ready,
        output busy, done, prod_ready, spad_w_en, spad_w_addr, spad_din,
               spad_r_addr, psum_out_valid, psum_out_data
    );

    modport master (
        output start, num_psums, num_accum, prod_valid, prod_data,
               spad_rd_data, psum_out_ready,
        input  busy, done, prod_ready, spad_w_en, spad_w_addr, spad_din,
               spad_r_addr, psum_out_valid, psum_out_data
    );
endinterface

// File: rtl/psum_accum_ctrl.sv
// ---------------------------------------------------------------------------
// psum_accum_ctrl
// Read-modify-write controller in front of a PE psum scratchpad. Each
// accepted signed product is added into its psum slot (slot = beat mod
// num_psums); after the last product the finished psums are drained in
// address order through a valid/ready output port.
//
// Ports:
//   clk   - clock, all state on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - psum_accum_ctrl_if.slave (control, product stream, spad, output)
//
// Spad timing assumed: writes land on the falling edge; read data is
// registered on the falling edge from spad_r_addr (old data on collision).
//
// Optional build macro PSUM_SAT_EN: when defined the accumulate saturates on
// signed overflow, otherwise it wraps in two's complement.
// ---------------------------------------------------------------------------
module psum_accum_ctrl #(
    parameter int MEM_DEPTH  = 24,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int CNT_WIDTH  = 8
) (
    input logic              clk,
    input logic              rst_n,
    psum_accum_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FLUSH,
        ST_DRAIN_RD,
        ST_DRAIN_OUT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] np_q, np_d;
    logic [CNT_WIDTH-1:0]  na_q, na_d;
    logic [ADDR_WIDTH-1:0] p_idx_q, p_idx_d;
    logic [CNT_WIDTH-1:0]  a_idx_q, a_idx_d;
    logic [ADDR_WIDTH-1:0] d_idx_q, d_idx_d;

    logic                  s1_valid_q, s1_valid_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_WIDTH-1:0] s1_prod_q, s1_prod_d;
    logic                  s1_first_q, s1_first_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  prod_ready_q, prod_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                  accept;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] addend;
    logic [DATA_WIDTH-1:0] sum;

    // The spad returns the old value when S2 writes the address S1 is
    // reading on the same falling edge, so the in-flight S2 result is
    // forwarded instead. The first product of a slot ignores the spad
    // entirely so stale contents from earlier passes never leak in.
    always_comb begin
        base   = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? s2_data_q
                                                          : bus.spad_rd_data;
        addend = s1_first_q ? '0 : base;
    end

`ifdef PSUM_SAT_EN
    logic [DATA_WIDTH:0] wide_sum;

    // Signed overflow shows up as the sign-extended sum disagreeing in its
    // top two bits; the extra top bit gives the true sign to clamp toward.
    always_comb begin
        wide_sum = {addend[DATA_WIDTH-1], addend} +
                   {s1_prod_q[DATA_WIDTH-1], s1_prod_q};
        if (wide_sum[DATA_WIDTH] != wide_sum[DATA_WIDTH-1]) begin
            sum = wide_sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            sum = wide_sum[DATA_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        sum = addend + s1_prod_q;
    end
`endif

    // Next-state logic: pass sequencing, product indexing (psum index is
    // the inner loop), the two-stage RMW pipeline and the drain handshake.
    // Registered outputs are derived from the next state so they line up
    // with the state they describe.
    always_comb begin
        state_d      = state_q;
        np_d         = np_q;
        na_d         = na_q;
        p_idx_d      = p_idx_q;
        a_idx_d      = a_idx_q;
        d_idx_d      = d_idx_q;
        s1_valid_d   = 1'b0;
        s1_addr_d    = s1_addr_q;
        s1_prod_d    = s1_prod_q;
        s1_first_d   = s1_first_q;
        s2_valid_d   = s1_valid_q;
        s2_addr_d    = s1_addr_q;
        s2_data_d    = sum;
        done_d       = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;

        accept    = (state_q == ST_ACCUM) && prod_ready_q && bus.prod_valid;
        last_beat = (p_idx_q == np_q - ADDR_WIDTH'(1)) &&
                    (a_idx_q == na_q - CNT_WIDTH'(1));

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_addr_d  = p_idx_q;
            s1_prod_d  = bus.prod_data;
            s1_first_d = (a_idx_q == '0);
            if (p_idx_q == np_q - ADDR_WIDTH'(1)) begin
                p_idx_d = '0;
                a_idx_d = a_idx_q + CNT_WIDTH'(1);
            end else begin
                p_idx_d = p_idx_q + ADDR_WIDTH'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if ((bus.num_psums == '0) || (bus.num_accum == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        np_d    = bus.num_psums;
                        na_d    = bus.num_accum;
                        p_idx_d = '0;
                        a_idx_d = '0;
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept && last_beat) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    d_idx_d = '0;
                    state_d = ST_DRAIN_RD;
                end
            end
            ST_DRAIN_RD: begin
                out_data_d  = bus.spad_rd_data;
                out_valid_d = 1'b1;
                state_d     = ST_DRAIN_OUT;
            end
            ST_DRAIN_OUT: begin
                if (bus.psum_out_ready) begin
                    out_valid_d = 1'b0;
                    d_idx_d     = d_idx_q + ADDR_WIDTH'(1);
                    if (d_idx_q == np_q - ADDR_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN_RD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d != ST_IDLE);
        prod_ready_d = (state_d == ST_ACCUM);
    end

    // All controller state, synchronous active-low reset. The spad itself
    // is external and is never cleared here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            np_q         <= '0;
            na_q         <= '0;
            p_idx_q      <= '0;
            a_idx_q      <= '0;
            d_idx_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_prod_q    <= '0;
            s1_first_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_addr_q    <= '0;
            s2_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            prod_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            np_q         <= np_d;
            na_q         <= na_d;
            p_idx_q      <= p_idx_d;
            a_idx_q      <= a_idx_d;
            d_idx_q      <= d_idx_d;
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            s1_prod_q    <= s1_prod_d;
            s1_first_q   <= s1_first_d;
            s2_valid_q   <= s2_valid_d;
            s2_addr_q    <= s2_addr_d;
            s2_data_q    <= s2_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            prod_ready_q <= prod_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    // The read port follows S1 while accumulating and the drain index while
    // draining; both sources are flops so the address is glitch-free by the
    // falling edge that samples it.
    assign bus.spad_r_addr    = (state_q == ST_DRAIN_RD) ? d_idx_q : s1_addr_q;
    assign bus.spad_w_en      = s2_valid_q;
    assign bus.spad_w_addr    = s2_addr_q;
    assign bus.spad_din       = s2_data_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.prod_ready     = prod_ready_q;
    assign bus.psum_out_valid = out_valid_q;
    assign bus.psum_out_data  = out_data_q;

endmodule
